cdce_serial_arbiter: RTL and testbench

Shares the single CDCE serial engine among NUM_REQ command sources, such as the ROM-driven power-up sequencer and a runtime host register port. It arbitrates round-robin, launches one 32-bit command per grant, and tracks each transaction until the engine reports ready. A lock mechanism lets one requester keep the engine for atomic multi-command sequences. The block sits between the command sources and the serial engine's start/ready/command interface.

---
 rtl/cdce_pkg.sv | 15 +
 rtl/cdce_serial_arbiter_rr_pick.sv | 33 +++
 rtl/cdce_serial_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cdce_serial_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdce_pkg.sv
// Shared definitions for the CDCE serial engine arbiter: command width,
// default watchdog limit and the arbiter state encoding.
package cdce_pkg;

    localparam int CDCE_CMD_W                  = 32;
    localparam int CDCE_TIMEOUT_CYCLES_DEFAULT = 4096;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        GUARD      = 2'd2,
        WAIT_READY = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cdce_serial_arbiter_rr_pick.sv
// cdce_rr_pick: combinational masked round-robin picker. The requester just
// above the pointer has highest priority; the pointer itself is searched last.
module cdce_rr_pick
    import cdce_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    // Two ascending passes: indices above the pointer first, then the wrap.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && eligible[i] && (PTR_W'(i) > ptr)) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && eligible[i] && (PTR_W'(i) <= ptr)) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdce_serial_arbiter.sv
// cdce_serial_arbiter: shares one CDCE serial engine between NUM_REQ command
// sources with round-robin arbitration and an owner lock for atomic sequences.
// Optional WAIT_READY watchdog enabled by defining CDCE_ARB_TIMEOUT_EN.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | no transaction; arbitrate when serial_ready is high
//   LAUNCH     | start_transaction and ack pulse for the winner
//   GUARD      | one cycle ignoring serial_ready (engine drops it late)
//   WAIT_READY | wait for serial_ready (or watchdog) to finish
module cdce_serial_arbiter
    import cdce_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int CMD_W          = CDCE_CMD_W,
    parameter int TIMEOUT_CYCLES = CDCE_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*CMD_W-1:0] cmd_in,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       cmpl,
    output logic [NUM_REQ-1:0]       grant,
    input  logic                     serial_ready,
    output logic                     start_transaction,
    output logic [CMD_W-1:0]         cdce_command,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cdce_serial_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [NUM_REQ-1:0] grant_nxt, ack_nxt, cmpl_nxt;
    logic [CMD_W-1:0]   cmd_nxt;
    logic               start_nxt, busy_nxt;
    logic               lock_ignore, lock_ignore_nxt;
    logic               owner_locked;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [CMD_W-1:0]   sel_cmd;
    logic               tmo_hit;

    // A held lock restricts arbitration to the last owner, unless a watchdog
    // abort has just released it.
    assign owner_locked = (|(lock & grant)) && !lock_ignore;
    assign eligible     = owner_locked ? (req & grant) : req;

    cdce_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (pick_oh),
        .valid    (pick_valid)
    );

    // Winner index and command mux from the one-hot pick.
    always_comb begin
        win_idx = '0;
        sel_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                win_idx = PTR_W'(i);
                sel_cmd = sel_cmd | cmd_in[i*CMD_W +: CMD_W];
            end
        end
    end

`ifdef CDCE_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Watchdog down-counter, loaded on entry to WAIT_READY; terminal count 0
    // marks the TIMEOUT_CYCLES-th WAIT_READY cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == GUARD) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
        end else if (state == WAIT_READY && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign tmo_hit = (state == WAIT_READY) && !serial_ready && (tmo_cnt == '0);

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        grant_nxt       = grant;
        cmd_nxt         = cdce_command;
        ack_nxt         = '0;
        cmpl_nxt        = '0;
        start_nxt       = 1'b0;
        lock_ignore_nxt = lock_ignore;
        case (state)
            IDLE: begin
                if (serial_ready && pick_valid) begin
                    state_nxt       = LAUNCH;
                    grant_nxt       = pick_oh;
                    ack_nxt         = pick_oh;
                    start_nxt       = 1'b1;
                    cmd_nxt         = sel_cmd;
                    ptr_nxt         = win_idx;
                    lock_ignore_nxt = 1'b0;
                end
            end
            LAUNCH: state_nxt = GUARD;
            GUARD:  state_nxt = WAIT_READY;
            WAIT_READY: begin
                if (serial_ready) begin
                    state_nxt = IDLE;
                    cmpl_nxt  = grant;
                end else if (tmo_hit) begin
                    state_nxt       = IDLE;
                    lock_ignore_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers; reset aborts everything silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            ptr               <= PTR_W'(NUM_REQ - 1);
            grant             <= '0;
            ack               <= '0;
            cmpl              <= '0;
            start_transaction <= 1'b0;
            cdce_command      <= '0;
            busy              <= 1'b0;
            lock_ignore       <= 1'b0;
        end else begin
            state             <= state_nxt;
            ptr               <= ptr_nxt;
            grant             <= grant_nxt;
            ack               <= ack_nxt;
            cmpl              <= cmpl_nxt;
            start_transaction <= start_nxt;
            cdce_command      <= cmd_nxt;
            busy              <= busy_nxt;
            lock_ignore       <= lock_ignore_nxt;
        end
    end

endmodule

// File: tb/tb_cdce_serial_arbiter.sv
// Scoreboard bench for cdce_serial_arbiter: a transaction-level model predicts
// launches/completions per clock edge; a negedge monitor compares.
module tb_cdce_serial_arbiter;

    localparam int NR = 3;
    localparam int CW = 32;
`ifdef CDCE_ARB_TIMEOUT_EN
    localparam int TMO    = 16;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 4096;
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk, reset_n;
    logic [NR-1:0]     req, lock, ack, cmpl, grant;
    logic [NR*CW-1:0]  cmd_in;
    logic              serial_ready, start_transaction, busy, timeout_err;
    logic [CW-1:0]     cdce_command;

    cdce_serial_arbiter #(
        .NUM_REQ        (NR),
        .CMD_W          (CW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .lock              (lock),
        .cmd_in            (cmd_in),
        .ack               (ack),
        .cmpl              (cmpl),
        .grant             (grant),
        .serial_ready      (serial_ready),
        .start_transaction (start_transaction),
        .cdce_command      (cdce_command),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int idx; logic [CW-1:0] cmd; } launch_t;
    launch_t lq[$];
    int      cq[$];

    bit            m_idle     = 1'b1;
    int            m_ptr      = NR - 1;
    int            m_owner    = -1;
    bit            m_lock_ign = 1'b0;
    bit            m_tmo      = 1'b0;
    int            m_launch   = 0;
    logic [CW-1:0] m_cmd      = '0;
    logic [NR-1:0] m_elig;
    int            m_w;

    function automatic int rr_pick(input logic [NR-1:0] elig, input int p);
        for (int k = 1; k <= NR; k++) begin
            if (elig[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        edge_cnt++;
        if (!reset_n) begin
            lq.delete();
            cq.delete();
            m_idle = 1'b1; m_ptr = NR - 1; m_owner = -1;
            m_lock_ign = 1'b0; m_tmo = 1'b0; m_cmd = '0;
        end else if (m_idle) begin
            if (m_owner >= 0 && lock[m_owner] && !m_lock_ign)
                m_elig = req & onehot(m_owner);
            else
                m_elig = req;
            if (serial_ready && m_elig != '0) begin
                m_w = rr_pick(m_elig, m_ptr);
                m_cmd = cmd_in[m_w*CW +: CW];
                lq.push_back('{idx: m_w, cmd: m_cmd});
                m_ptr = m_w; m_owner = m_w; m_lock_ign = 1'b0;
                m_idle = 1'b0; m_launch = edge_cnt;
            end
        end else begin
            if (edge_cnt >= m_launch + 3 && serial_ready) begin
                cq.push_back(m_owner);
                m_idle = 1'b1;
            end else if (TMO_EN && edge_cnt == m_launch + 2 + TMO) begin
                m_idle = 1'b1; m_lock_ign = 1'b1; m_tmo = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    int last_start = -100, prev_start = -100, last_cmpl = -100;
    launch_t le;
    int      ce;

    always @(negedge clk) begin
        if (reset_n) begin
            check("grant", grant, onehot(m_owner));
            check("busy", busy, !m_idle);
            check("timeout_err", timeout_err, m_tmo);
            check("cdce_command", cdce_command, m_cmd);
            if (lq.size() != 0) begin
                le = lq.pop_front();
                check("launch_start", start_transaction, 1);
                check("launch_ack", ack, onehot(le.idx));
            end else begin
                check("spurious_launch", {start_transaction, ack}, 0);
            end
            if (cq.size() != 0) begin
                ce = cq.pop_front();
                check("cmpl", cmpl, onehot(ce));
            end else begin
                check("spurious_cmpl", cmpl, 0);
            end
            if (start_transaction) begin
                prev_start = last_start;
                last_start = edge_cnt;
            end
            if (cmpl != '0) last_cmpl = edge_cnt;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_any_ack(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("ack_wait_budget", ok, 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_cmpl"}, cmpl, 0);
        check({tag, "_start"}, start_transaction, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd"}, cdce_command, 0);
        check({tag, "_tmo"}, timeout_err, 0);
    endtask

    int e0, r0, n1;

    initial begin
        reset_n = 1'b0; req = '0; lock = '0; cmd_in = '0; serial_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        idle_cycles(2);

        // single request with immediate ready
        cmd_in[0*CW +: CW] = 32'h1234_5678;
        req = 3'b001;
        e0 = edge_cnt;
        wait_any_ack(10);
        req = '0;
        idle_cycles(6);
        check("single_start_latency", last_start, e0 + 1);
        check("single_cmpl_latency", last_cmpl - last_start, 3);

        // contention between requesters 0 and 1
        cmd_in[0*CW +: CW] = 32'hAAAA_0000;
        cmd_in[1*CW +: CW] = 32'hBBBB_1111;
        req = 3'b011;
        idle_cycles(21);
        check("contention_spacing", last_start - prev_start, 4);
        req = '0;
        idle_cycles(6);

        // requester 1 locks for three commands while requester 0 waits
        lock[1] = 1'b1;
        req = 3'b011;
        n1 = 0;
        for (int c = 0; c < 80 && n1 < 3; c++) begin
            @(negedge clk);
            if (ack[1]) begin
                n1++;
                cmd_in[1*CW +: CW] = 32'hC0DE_0000 + n1;
                if (n1 == 3) begin
                    lock[1] = 1'b0;
                    req[1]  = 1'b0;
                end
            end
        end
        check("lock_grants_to_1", n1, 3);
        wait_any_ack(20);
        check("after_unlock_ack", ack, 3'b001);
        req = '0;
        idle_cycles(6);

        // slow engine: ready low for 50 cycles after launch
        cmd_in[2*CW +: CW] = 32'h5105_E000;
        req = 3'b100;
        wait_any_ack(10);
        req = '0;
        serial_ready = 1'b0;
        idle_cycles(50);
        r0 = edge_cnt;
        serial_ready = 1'b1;
        idle_cycles(3);
        check("slow_cmpl_edge", last_cmpl, r0 + 1);
        idle_cycles(3);

        // engine stuck: watchdog abort or indefinite wait
        req = 3'b001;
        wait_any_ack(10);
        req = '0;
        serial_ready = 1'b0;
`ifdef CDCE_ARB_TIMEOUT_EN
        idle_cycles(30);
        check("stuck_timeout_err", timeout_err, 1);
        check("stuck_busy", busy, 0);
`else
        idle_cycles(1000);
        check("stuck_busy", busy, 1);
        check("stuck_timeout_err", timeout_err, 0);
`endif
        check("stuck_no_cmpl", last_cmpl < last_start, 1);
        serial_ready = 1'b1;
        idle_cycles(5);

        // reset asserted while in GUARD
        req = 3'b011;
        wait_any_ack(10);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("guard_rst_grant", grant, 0);
        check("guard_rst_start", start_transaction, 0);
        check("guard_rst_busy", busy, 0);
        check("guard_rst_cmd", cdce_command, 0);
        check("guard_rst_ack_cmpl", {ack, cmpl}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_any_ack(10);
        check("post_reset_first_ack", ack, 3'b001);
        req = '0;
        idle_cycles(6);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 2) == 0) cmd_in[i*CW +: CW] = $urandom;
                        else req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    cmd_in[i*CW +: CW] = $urandom;
                    req[i] = 1'b1;
                end
                if ($urandom_range(0, 7) == 0) lock[i] = ~lock[i];
            end
            serial_ready = ($urandom_range(0, 3) != 0);
        end
        req = '0; lock = '0; serial_ready = 1'b1;
        idle_cycles(10);
        check("drain_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
